audio_sample_scheduler: RTL and testbench

Buffers stereo L-PCM samples arriving at the audio sample rate and groups them into HDMI audio sample packets of up to four samples. Each packet carries the IEC 60958 frame position of its first sample. The block sits between the audio source (samples already synchronised to `clk_pixel`) and the audio sample packet assembler. It answers slot requests from the data-island packet scheduler and holds each packet until the serializer acknowledges it.

---
 rtl/audio_sample_scheduler.sv | 173 +++++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_scheduler.sv
// audio_sample_scheduler
//
// Buffers stereo L-PCM pairs (already in the pixel clock domain) in a small
// circular FIFO and hands them to the audio sample packet assembler in groups
// of up to four, together with the IEC 60958 frame index of the first pair.
// A packet is built when the data-island scheduler offers a slot and is held
// until the serializer acknowledges it.
//
// Ports:
//   clk_pixel                  pixel clock, the only clock
//   reset_n                    asynchronous active-low reset
//   sample_valid               strobe: sample_left/sample_right carry a new pair
//   sample_left, sample_right  channel samples, SAMPLE_WIDTH bits each
//   packet_request             strobe: an audio packet slot is available
//   packet_ack                 serializer consumed the presented packet
//   packet_valid               packet outputs are valid and stable
//   frame_counter              frame index (0..191) of slot 0
//   audio_sample_word          [slot][channel] samples, channel 0 = left
//   audio_sample_word_present  slot-present mask
//   samples_available          FIFO not empty
//   overflow                   one-cycle pulse when an incoming pair is dropped

module audio_sample_scheduler #(
  parameter int FIFO_DEPTH   = 8,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                                 clk_pixel,
  input  logic                                 reset_n,
  input  logic                                 sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]              sample_left,
  input  logic [SAMPLE_WIDTH-1:0]              sample_right,
  input  logic                                 packet_request,
  input  logic                                 packet_ack,
  output logic                                 packet_valid,
  output logic [7:0]                           frame_counter,
  output logic [3:0][1:0][SAMPLE_WIDTH-1:0]    audio_sample_word,
  output logic [3:0]                           audio_sample_word_present,
  output logic                                 samples_available,
  output logic                                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  // Index 0 = left, index 1 = right, matching the packet channel layout.
  typedef logic [1:0][SAMPLE_WIDTH-1:0] pair_t;

  state_t        state;
  pair_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    next_frame;

  // Extra pointer MSB distinguishes full from empty, so the difference is the
  // fill level without a separate counter.
  logic [PW-1:0]                      count;
  logic                               pop;
  logic [2:0]                         pop_n;
  logic                               push_ok;
  logic [PW-1:0]                      wr_next;
  logic [PW-1:0]                      rd_next;
  logic [8:0]                         frame_sum;
  logic [7:0]                         frame_wrapped;
  logic [3:0][1:0][SAMPLE_WIDTH-1:0]  slot_words;
  logic [3:0]                         slot_mask;

  assign count = wr_ptr - rd_ptr;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop           = 1'b0;
    pop_n         = 3'd0;
    push_ok       = 1'b0;
    wr_next       = wr_ptr;
    rd_next       = rd_ptr;
    frame_sum     = 9'd0;
    frame_wrapped = next_frame;
    slot_words    = '0;
    slot_mask     = 4'b0000;

    pop = (state == IDLE) && packet_request && (count != '0);
    if (pop) begin
      pop_n = (count >= PW'(4)) ? 3'd4 : 3'(count);
    end

    // A full FIFO still accepts a pair when a pop frees space this cycle.
    push_ok = sample_valid && ((count < PW'(FIFO_DEPTH)) || pop);

    wr_next = wr_ptr + PW'(push_ok);
    rd_next = rd_ptr + PW'(pop_n);

    frame_sum = {1'b0, next_frame} + {6'b0, pop_n};
    if (frame_sum >= 9'd192) begin
      frame_wrapped = 8'(frame_sum - 9'd192);
    end else begin
      frame_wrapped = 8'(frame_sum);
    end

    // Reads see the array before this cycle's write, so a same-cycle push is
    // never part of the popped group, even when it lands on a popped slot.
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < pop_n) begin
        slot_words[i] = mem[rd_ptr[AW-1:0] + AW'(i)];
      end
    end

    case (pop_n)
      3'd1:    slot_mask = 4'b0001;
      3'd2:    slot_mask = 4'b0011;
      3'd3:    slot_mask = 4'b0111;
      3'd4:    slot_mask = 4'b1111;
      default: slot_mask = 4'b0000;
    endcase
  end

  // NOTE: sample storage has no reset; emptying the FIFO only needs the
  // pointers cleared, and stale entries are never read before being rewritten.
  always_ff @(posedge clk_pixel) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {sample_right, sample_left};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state                     <= IDLE;
      wr_ptr                    <= '0;
      rd_ptr                    <= '0;
      next_frame                <= 8'd0;
      packet_valid              <= 1'b0;
      frame_counter             <= 8'd0;
      audio_sample_word         <= '0;
      audio_sample_word_present <= 4'b0000;
      samples_available         <= 1'b0;
      overflow                  <= 1'b0;
    end else begin
      wr_ptr            <= wr_next;
      rd_ptr            <= rd_next;
      samples_available <= (wr_next != rd_next);
      overflow          <= sample_valid && !push_ok;

      case (state)
        IDLE: begin
          if (pop) begin
            state                     <= PRESENT;
            packet_valid              <= 1'b1;
            audio_sample_word         <= slot_words;
            audio_sample_word_present <= slot_mask;
            frame_counter             <= next_frame;
            next_frame                <= frame_wrapped;
          end
        end
        PRESENT: begin
          // Packet outputs hold; requests here are dropped, not queued.
          if (packet_ack) begin
            state        <= IDLE;
            packet_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed testbench for audio_sample_scheduler. Inputs change on the falling
// edge, the DUT captures on the rising edge, and outputs are observed on the
// following falling edge.

module tb_audio_sample_scheduler;

  localparam int SW = 24;

  logic                       clk_pixel = 1'b0;
  logic                       reset_n   = 1'b1;
  logic                       sample_valid;
  logic [SW-1:0]              sample_left;
  logic [SW-1:0]              sample_right;
  logic                       packet_request;
  logic                       packet_ack;
  logic                       packet_valid;
  logic [7:0]                 frame_counter;
  logic [3:0][1:0][SW-1:0]    audio_sample_word;
  logic [3:0]                 audio_sample_word_present;
  logic                       samples_available;
  logic                       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk_pixel = ~clk_pixel;

  audio_sample_scheduler #(
    .FIFO_DEPTH  (8),
    .SAMPLE_WIDTH(SW)
  ) dut (
    .clk_pixel                (clk_pixel),
    .reset_n                  (reset_n),
    .sample_valid             (sample_valid),
    .sample_left              (sample_left),
    .sample_right             (sample_right),
    .packet_request           (packet_request),
    .packet_ack               (packet_ack),
    .packet_valid             (packet_valid),
    .frame_counter            (frame_counter),
    .audio_sample_word        (audio_sample_word),
    .audio_sample_word_present(audio_sample_word_present),
    .samples_available        (samples_available),
    .overflow                 (overflow)
  );

  // ---------------- stimulus helpers (called at a falling edge) ----------
  task automatic do_reset();
    sample_valid   = 1'b0;
    sample_left    = '0;
    sample_right   = '0;
    packet_request = 1'b0;
    packet_ack     = 1'b0;
    reset_n        = 1'b0;
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    @(negedge clk_pixel);
  endtask

  task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r);
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    @(negedge clk_pixel);
    sample_valid = 1'b0;
  endtask

  task automatic request();
    packet_request = 1'b1;
    @(negedge clk_pixel);
    packet_request = 1'b0;
  endtask

  task automatic ack();
    packet_ack = 1'b1;
    @(negedge clk_pixel);
    packet_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset_n = 1'b0;
    sample_valid   = 1'b0;
    sample_left    = '0;
    sample_right   = '0;
    packet_request = 1'b0;
    packet_ack     = 1'b0;
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    total++; if (packet_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", packet_valid); end
    total++; if (frame_counter !== 8'd0) begin bad++; $display("FAIL reset_frame got=%0d want=0", frame_counter); end
    total++; if (audio_sample_word !== '0) begin bad++; $display("FAIL reset_words got=%h want=0", audio_sample_word); end
    total++; if (audio_sample_word_present !== 4'b0000) begin bad++; $display("FAIL reset_present got=%b want=0000", audio_sample_word_present); end
    total++; if (samples_available !== 1'b0) begin bad++; $display("FAIL reset_avail got=%b want=0", samples_available); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    reset_n = 1'b1;
    @(negedge clk_pixel);
  endtask

  task automatic test_basic();
    do_reset();
    for (int k = 1; k <= 3; k++) push(24'(k), 24'h100000 + 24'(k));
    total++; if (samples_available !== 1'b1) begin bad++; $display("FAIL basic_avail got=%b want=1", samples_available); end
    total++; if (packet_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_valid got=%b want=0", packet_valid); end
    request();
    total++; if (packet_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", packet_valid); end
    total++; if (audio_sample_word_present !== 4'b0111) begin bad++; $display("FAIL basic_present got=%b want=0111", audio_sample_word_present); end
    total++; if (frame_counter !== 8'd0) begin bad++; $display("FAIL basic_frame got=%0d want=0", frame_counter); end
    total++; if (audio_sample_word[0][0] !== 24'h000001 || audio_sample_word[0][1] !== 24'h100001) begin bad++; $display("FAIL basic_slot0 got=%h/%h want=000001/100001", audio_sample_word[0][0], audio_sample_word[0][1]); end
    total++; if (audio_sample_word[2][0] !== 24'h000003 || audio_sample_word[2][1] !== 24'h100003) begin bad++; $display("FAIL basic_slot2 got=%h/%h want=000003/100003", audio_sample_word[2][0], audio_sample_word[2][1]); end
    total++; if (audio_sample_word[3] !== '0) begin bad++; $display("FAIL basic_slot3 got=%h want=0", audio_sample_word[3]); end
    total++; if (samples_available !== 1'b0) begin bad++; $display("FAIL basic_avail_after got=%b want=0", samples_available); end
    ack();
    total++; if (packet_valid !== 1'b0) begin bad++; $display("FAIL basic_ack got=%b want=0", packet_valid); end
    request();
    total++; if (packet_valid !== 1'b0) begin bad++; $display("FAIL basic_empty_req got=%b want=0", packet_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 6; k++) push(24'(k), 24'h100000 + 24'(k));
    request();
    total++; if (audio_sample_word_present !== 4'b1111 || frame_counter !== 8'd0) begin bad++; $display("FAIL b2b_first got=%b/%0d want=1111/0", audio_sample_word_present, frame_counter); end
    total++; if (audio_sample_word[3][0] !== 24'h000004) begin bad++; $display("FAIL b2b_first_slot3 got=%h want=000004", audio_sample_word[3][0]); end
    ack();
    request();
    total++; if (packet_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", packet_valid); end
    total++; if (audio_sample_word_present !== 4'b0011 || frame_counter !== 8'd4) begin bad++; $display("FAIL b2b_second got=%b/%0d want=0011/4", audio_sample_word_present, frame_counter); end
    total++; if (audio_sample_word[0][0] !== 24'h000005 || audio_sample_word[1][1] !== 24'h100006) begin bad++; $display("FAIL b2b_second_data got=%h/%h want=000005/100006", audio_sample_word[0][0], audio_sample_word[1][1]); end
    total++; if (audio_sample_word[2] !== '0 || audio_sample_word[3] !== '0) begin bad++; $display("FAIL b2b_second_zero got=%h want=0", audio_sample_word[3:2]); end
    total++; if (samples_available !== 1'b0) begin bad++; $display("FAIL b2b_avail got=%b want=0", samples_available); end
    ack();
  endtask

  task automatic test_frame_wrap();
    do_reset();
    for (int p = 0; p < 47; p++) begin
      for (int k = 0; k < 4; k++) push(24'(p * 4 + k), 24'h0);
      request();
      total++; if (frame_counter !== 8'(p * 4)) begin bad++; $display("FAIL wrap_frame_%0d got=%0d want=%0d", p, frame_counter, p * 4); end
      ack();
    end
    for (int k = 0; k < 3; k++) push(24'h1, 24'h2);
    request();
    total++; if (frame_counter !== 8'd188 || audio_sample_word_present !== 4'b0111) begin bad++; $display("FAIL wrap_188 got=%0d/%b want=188/0111", frame_counter, audio_sample_word_present); end
    ack();
    for (int k = 0; k < 4; k++) push(24'h3, 24'h4);
    request();
    total++; if (frame_counter !== 8'd191) begin bad++; $display("FAIL wrap_191 got=%0d want=191", frame_counter); end
    ack();
    for (int k = 0; k < 4; k++) push(24'h5, 24'h6);
    request();
    total++; if (frame_counter !== 8'd3) begin bad++; $display("FAIL wrap_3 got=%0d want=3", frame_counter); end
    ack();
  endtask

  task automatic test_overflow();
    logic early_ovf;
    do_reset();
    early_ovf = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push(24'(k), 24'h200000 + 24'(k));
      if (overflow !== 1'b0) early_ovf = 1'b1;
    end
    total++; if (early_ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=1 want=0"); end
    push(24'd9, 24'h200009);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
    @(negedge clk_pixel);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    request();
    total++; if (audio_sample_word[0][0] !== 24'd1 || audio_sample_word[3][0] !== 24'd4 || audio_sample_word[3][1] !== 24'h200004) begin bad++; $display("FAIL ovf_pairs got=%h/%h/%h want=000001/000004/200004", audio_sample_word[0][0], audio_sample_word[3][0], audio_sample_word[3][1]); end
    ack();
    // Refill to 8 (pairs 5..8 still held, plus 10..13), then push+pop together.
    for (int k = 10; k <= 13; k++) push(24'(k), 24'h200000 + 24'(k));
    sample_valid   = 1'b1;
    sample_left    = 24'd14;
    sample_right   = 24'h20000E;
    packet_request = 1'b1;
    @(negedge clk_pixel);
    sample_valid   = 1'b0;
    packet_request = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_full_pushpop got=%b want=0", overflow); end
    total++; if (audio_sample_word[0][0] !== 24'd5 || audio_sample_word[3][0] !== 24'd8) begin bad++; $display("FAIL ovf_full_pairs got=%h/%h want=000005/000008", audio_sample_word[0][0], audio_sample_word[3][0]); end
    ack();
    request();
    total++; if (audio_sample_word_present !== 4'b1111 || audio_sample_word[0][0] !== 24'd10 || audio_sample_word[3][0] !== 24'd13) begin bad++; $display("FAIL ovf_count5_a got=%b/%h/%h want=1111/00000a/00000d", audio_sample_word_present, audio_sample_word[0][0], audio_sample_word[3][0]); end
    ack();
    request();
    total++; if (audio_sample_word_present !== 4'b0001 || audio_sample_word[0][1] !== 24'h20000E) begin bad++; $display("FAIL ovf_count5_b got=%b/%h want=0001/20000e", audio_sample_word_present, audio_sample_word[0][1]); end
    total++; if (samples_available !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", samples_available); end
    ack();
  endtask

  task automatic test_present_hold();
    logic moved;
    do_reset();
    for (int k = 1; k <= 5; k++) push(24'h300000 + 24'(k), 24'h400000 + 24'(k));
    request();
    moved = 1'b0;
    packet_request = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_pixel);
      if (packet_valid !== 1'b1 || frame_counter !== 8'd0 || audio_sample_word_present !== 4'b1111 ||
          audio_sample_word[0][0] !== 24'h300001 || audio_sample_word[3][1] !== 24'h400004 ||
          samples_available !== 1'b1)
        moved = 1'b1;
    end
    packet_request = 1'b0;
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL hold_stable got=1 want=0"); end
    ack();
    total++; if (packet_valid !== 1'b0) begin bad++; $display("FAIL hold_no_queue got=%b want=0", packet_valid); end
    ack();
    total++; if (packet_valid !== 1'b0 || samples_available !== 1'b1) begin bad++; $display("FAIL hold_idle_ack got=%b/%b want=0/1", packet_valid, samples_available); end
    request();
    total++; if (frame_counter !== 8'd4 || audio_sample_word_present !== 4'b0001 || audio_sample_word[0][0] !== 24'h300005) begin bad++; $display("FAIL hold_next got=%0d/%b/%h want=4/0001/300005", frame_counter, audio_sample_word_present, audio_sample_word[0][0]); end
    ack();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 6; k++) push(24'h500000 + 24'(k), 24'h600000 + 24'(k));
    request();
    total++; if (packet_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", packet_valid); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (packet_valid !== 1'b0 || frame_counter !== 8'd0 || audio_sample_word !== '0 ||
                 audio_sample_word_present !== 4'b0000 || samples_available !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL mid_async got=%b/%0d/%b/%b/%b want=all 0", packet_valid, frame_counter, audio_sample_word_present, samples_available, overflow);
    end
    @(negedge clk_pixel);
    reset_n = 1'b1;
    @(negedge clk_pixel);
    push(24'hA00001, 24'hB00001);
    push(24'hA00002, 24'hB00002);
    request();
    total++; if (frame_counter !== 8'd0 || audio_sample_word_present !== 4'b0011) begin bad++; $display("FAIL mid_after got=%0d/%b want=0/0011", frame_counter, audio_sample_word_present); end
    total++; if (audio_sample_word[0][0] !== 24'hA00001 || audio_sample_word[1][1] !== 24'hB00002) begin bad++; $display("FAIL mid_data got=%h/%h want=a00001/b00002", audio_sample_word[0][0], audio_sample_word[1][1]); end
    total++; if (samples_available !== 1'b0) begin bad++; $display("FAIL mid_avail got=%b want=0", samples_available); end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_wrap();
    test_overflow();
    test_present_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
